// File: rtl/fb_pkg.sv
// fb_pkg -- shared constants and types for the 160x120 pixel-plot framebuffer.
//   FB_WIDTH/FB_HEIGHT/FB_PIXELS/FB_ADDR_W : framebuffer geometry
//   FB_COLOUR_W                            : default colour depth (colour_t width)
//   plot_entry_t                           : one queued plot request {x, y, colour}
//   state_t                                : receiver state {IDLE, DRAIN, CLEAR}
package fb_pkg;

  localparam int FB_WIDTH    = 160;
  localparam int FB_HEIGHT   = 120;
  localparam int FB_PIXELS   = 19200;
  localparam int FB_ADDR_W   = 15;
  localparam int FB_COLOUR_W = 3;

  typedef logic [FB_COLOUR_W-1:0] colour_t;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    colour_t    colour;
  } plot_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_t;

endpackage

// File: rtl/fb_addr_calc.sv
// fb_addr_calc -- combinational pixel coordinate to linear address.
//   x_i    : column 0..159
//   y_i    : row 0..119
//   addr_o : y*160 + x, built as (y<<7) + (y<<5) + x at 15 bits
module fb_addr_calc
  import fb_pkg::*;
(
  input  logic [7:0]           x_i,
  input  logic [6:0]           y_i,
  output logic [FB_ADDR_W-1:0] addr_o
);

  logic [FB_ADDR_W-1:0] y_w;
  logic [FB_ADDR_W-1:0] x_w;

  assign y_w    = FB_ADDR_W'(y_i);
  assign x_w    = FB_ADDR_W'(x_i);
  assign addr_o = (y_w << 7) + (y_w << 5) + x_w;

endmodule

// File: rtl/fb_plot_receiver.sv
// fb_plot_receiver -- receives pixel plots, queues them in a small FIFO and
// writes them into an on-chip framebuffer; a read port fetches pixels.
// Optional clear engine built when macro FB_CLEAR_EN is defined.
//   CLOCK_50, reset_n        : clock, asynchronous active-low reset
//   x, y, colour, plot/ready : plot request handshake (accepted on plot && ready)
//   rd_en, rd_addr           : read request, 1-cycle latency
//   rd_valid, rd_colour      : read response (colour 0 for addresses >= 19200)
//   drop_count               : saturating count of out-of-range plots
//   clear, clear_colour      : start a fill of the whole buffer (FB_CLEAR_EN only)
//   clear_busy, idle         : engine status
// The FIFO stores colour as colour_t, so COLOUR_W is expected to equal FB_COLOUR_W.
module fb_plot_receiver
  import fb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int COLOUR_W   = FB_COLOUR_W
) (
  input  logic                 CLOCK_50,
  input  logic                 reset_n,
  input  logic [7:0]           x,
  input  logic [6:0]           y,
  input  logic [COLOUR_W-1:0]  colour,
  input  logic                 plot,
  output logic                 ready,
  input  logic                 rd_en,
  input  logic [FB_ADDR_W-1:0] rd_addr,
  output logic                 rd_valid,
  output logic [COLOUR_W-1:0]  rd_colour,
  output logic [15:0]          drop_count,
  input  logic                 clear,
  input  logic [COLOUR_W-1:0]  clear_colour,
  output logic                 clear_busy,
  output logic                 idle
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // ---------------------------------------------------------------------------
  // Plot FIFO
  // ---------------------------------------------------------------------------
  plot_entry_t            fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]       count_q;
  logic                   fifo_empty, fifo_full;
  logic                   in_range, accept, push, pop;
  plot_entry_t            push_entry, head_entry;
  state_t                 state;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign ready      = !fifo_full && (state == IDLE);
  assign in_range   = (x < 8'(FB_WIDTH)) && (y < 7'(FB_HEIGHT));
  assign accept     = plot && ready;
  assign push       = accept && in_range;
  // Reads own the single RAM port, so a pending read holds the FIFO head.
  assign pop        = !rd_en && !fifo_empty;

  assign push_entry = '{x: x, y: y, colour: colour_t'(colour)};
  assign head_entry = fifo_mem[rd_ptr_q];

  always_ff @(posedge CLOCK_50) begin
    if (push) fifo_mem[wr_ptr_q] <= push_entry;
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Drop counter (out-of-range plots are accepted but discarded)
  // ---------------------------------------------------------------------------
  logic [15:0] drop_q;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      drop_q <= '0;
    end else if (accept && !in_range && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_count = drop_q;

  // ---------------------------------------------------------------------------
  // Clear engine
  // ---------------------------------------------------------------------------
  logic                 clr_we;
  logic [FB_ADDR_W-1:0] clr_addr;
  logic [COLOUR_W-1:0]  clr_colour;

`ifdef FB_CLEAR_EN
  state_t               state_q, state_d;
  logic [FB_ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [COLOUR_W-1:0]  clr_colour_q, clr_colour_d;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      clr_addr_q   <= '0;
      clr_colour_q <= '0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      clr_colour_q <= clr_colour_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    clr_colour_d = clr_colour_q;
    unique case (state_q)
      IDLE: begin
        if (clear) begin
          state_d      = DRAIN;
          clr_colour_d = clear_colour;
        end
      end
      DRAIN: begin
        // No new pushes are possible here, so an empty FIFO stays empty.
        if (fifo_empty) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end
      end
      CLEAR: begin
        if (!rd_en) begin
          if (clr_addr_q == FB_ADDR_W'(FB_PIXELS - 1)) begin
            state_d = IDLE;
          end else begin
            clr_addr_d = clr_addr_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign state      = state_q;
  assign clr_we     = (state_q == CLEAR) && !rd_en;
  assign clr_addr   = clr_addr_q;
  assign clr_colour = clr_colour_q;
`else
  logic unused_clear;

  assign unused_clear = ^{clear, clear_colour};
  assign state        = IDLE;
  assign clr_we       = 1'b0;
  assign clr_addr     = '0;
  assign clr_colour   = '0;
`endif

  assign clear_busy = (state != IDLE);
  assign idle       = fifo_empty && (state == IDLE);

  // ---------------------------------------------------------------------------
  // Framebuffer RAM: one access per cycle, read wins over FIFO and clear writes
  // ---------------------------------------------------------------------------
  logic [COLOUR_W-1:0]  fb_mem [FB_PIXELS];
  logic [FB_ADDR_W-1:0] head_addr;
  logic [FB_ADDR_W-1:0] wr_addr;
  logic [COLOUR_W-1:0]  wr_data;
  logic                 mem_we;
  logic                 rd_in_range;
  logic [COLOUR_W-1:0]  mem_rd_q;
  logic                 rd_valid_q, rd_oob_q;

  fb_addr_calc u_addr_calc (
    .x_i    (head_entry.x),
    .y_i    (head_entry.y),
    .addr_o (head_addr)
  );

  // During CLEAR the FIFO is empty, so pop and clr_we never coincide.
  assign mem_we      = pop || clr_we;
  assign wr_addr     = clr_we ? clr_addr : head_addr;
  assign wr_data     = clr_we ? clr_colour : COLOUR_W'(head_entry.colour);
  assign rd_in_range = (rd_addr < FB_ADDR_W'(FB_PIXELS));

  always_ff @(posedge CLOCK_50) begin
    if (mem_we) fb_mem[wr_addr] <= wr_data;
    if (rd_en && rd_in_range) mem_rd_q <= fb_mem[rd_addr];
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q <= 1'b0;
      rd_oob_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      rd_oob_q   <= rd_en && !rd_in_range;
    end
  end

  // The RAM output register has no reset; gating keeps rd_colour defined.
  assign rd_valid  = rd_valid_q;
  assign rd_colour = (rd_valid_q && !rd_oob_q) ? mem_rd_q : '0;

endmodule

// File: tb/tb_fb_plot_receiver.sv
// tb_fb_plot_receiver -- directed self-checking bench for fb_plot_receiver.
// Clear-engine scenarios are compiled only when FB_CLEAR_EN is defined.
module tb_fb_plot_receiver;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n  = 1'b0;
  logic [7:0]  x        = '0;
  logic [6:0]  y        = '0;
  logic [2:0]  colour   = '0;
  logic        plot     = 1'b0;
  logic        ready;
  logic        rd_en    = 1'b0;
  logic [14:0] rd_addr  = '0;
  logic        rd_valid;
  logic [2:0]  rd_colour;
  logic [15:0] drop_count;
  logic        clear    = 1'b0;
  logic [2:0]  clear_colour = '0;
  logic        clear_busy;
  logic        idle;

  int n_tests = 0;
  int n_fail  = 0;

  fb_plot_receiver #(.FIFO_DEPTH(4), .COLOUR_W(3)) dut (
    .CLOCK_50     (CLOCK_50),
    .reset_n      (reset_n),
    .x            (x),
    .y            (y),
    .colour       (colour),
    .plot         (plot),
    .ready        (ready),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_valid     (rd_valid),
    .rd_colour    (rd_colour),
    .drop_count   (drop_count),
    .clear        (clear),
    .clear_colour (clear_colour),
    .clear_busy   (clear_busy),
    .idle         (idle)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Single-cycle plot; caller guarantees ready is high.
  task automatic do_plot(input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc);
    x = px; y = py; colour = pc; plot = 1'b1;
    tick();
    plot = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int cyc = 0;
    while (!idle && cyc < 100) begin
      tick();
      cyc++;
    end
    check(tag, 32'(idle), 32'd1);
  endtask

  task automatic read_px(input string tag, input logic [14:0] a, input logic [2:0] exp);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    check({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check({tag, "_data"},  32'(rd_colour), 32'(exp));
  endtask

  initial begin
    int accepts;
    int k;
    logic [7:0] fx [4];
    logic [2:0] fc [4];
    fx[0] = 8'd10; fc[0] = 3'd3;
    fx[1] = 8'd11; fc[1] = 3'd4;
    fx[2] = 8'd10; fc[2] = 3'd5;
    fx[3] = 8'd12; fc[3] = 3'd6;

    // Reset state
    #25;
    check("rst_rd_valid",   32'(rd_valid),   32'd0);
    check("rst_rd_colour",  32'(rd_colour),  32'd0);
    check("rst_drop",       32'(drop_count), 32'd0);
    check("rst_clear_busy", 32'(clear_busy), 32'd0);
    check("rst_idle",       32'(idle),       32'd1);
    check("rst_ready",      32'(ready),      32'd1);
    reset_n = 1'b1;
    tick();

    // Basic plot, 2-edge write latency then read: (5,3) -> 485
    do_plot(8'd5, 7'd3, 3'b010);
    tick();
    read_px("plot_5_3", 15'd485, 3'b010);
    tick();
    check("rd_valid_pulse", 32'(rd_valid), 32'd0);

    // Known values around the drop targets, then two out-of-range plots
    do_plot(8'd0, 7'd0, 3'd1);
    do_plot(8'd0, 7'd1, 3'd1);
    wait_idle("pre_drop_idle");
    x = 8'd160; y = 7'd0; colour = 3'd7; plot = 1'b1;
    check("drop1_ready", 32'(ready), 32'd1);
    tick();
    x = 8'd0; y = 7'd120;
    check("drop2_ready", 32'(ready), 32'd1);
    tick();
    plot = 1'b0;
    tick();
    check("drop_count", 32'(drop_count), 32'd2);
    check("drop_idle",  32'(idle),       32'd1);
    read_px("addr0_kept",   15'd0,     3'd1);
    read_px("addr160_kept", 15'd160,   3'd1);
    read_px("oob_read",     15'd19200, 3'd0);

    // Sustained throughput: ready stays high with no reads
    for (int i = 0; i < 4; i++) begin
      x = 8'(20 + i); y = 7'd5; colour = 3'(i + 1); plot = 1'b1;
      check($sformatf("stream_ready%0d", i), 32'(ready), 32'd1);
      tick();
    end
    plot = 1'b0;
    wait_idle("stream_idle");
    read_px("stream_last", 15'd823, 3'd4);

    // Continuous reads block the FIFO: exactly 4 accepts, then ready drops
    rd_en = 1'b1; rd_addr = 15'd0;
    accepts = 0; k = 0;
    for (int i = 0; i < 6; i++) begin
      if (k < 4) begin
        x = fx[k]; y = 7'd10; colour = fc[k]; plot = 1'b1;
      end else begin
        x = 8'd13; y = 7'd10; colour = 3'd7; plot = 1'b1;
      end
      if (plot && ready) begin
        accepts++;
        k++;
      end
      tick();
    end
    plot = 1'b0;
    check("fill_accepts", 32'(accepts), 32'd4);
    check("fill_ready",   32'(ready),   32'd0);
    rd_en = 1'b0;
    wait_idle("fill_drain_idle");
    read_px("order_1610", 15'd1610, 3'd5);
    read_px("order_1611", 15'd1611, 3'd4);
    read_px("order_1612", 15'd1612, 3'd6);

    // Reset with entries queued: FIFO is discarded, memory keeps old data
    do_plot(8'd30, 7'd30, 3'd1);
    do_plot(8'd160, 7'd0, 3'd0);
    wait_idle("pre_rst_idle");
    rd_en = 1'b1; rd_addr = 15'd0;
    do_plot(8'd30, 7'd30, 3'd6);
    rd_en = 1'b1;
    #5 reset_n = 1'b0;
    rd_en = 1'b0;
    #2;
    check("arst_idle",     32'(idle),       32'd1);
    check("arst_drop",     32'(drop_count), 32'd0);
    check("arst_rd_valid", 32'(rd_valid),   32'd0);
    check("arst_ready",    32'(ready),      32'd1);
    tick();
    #3 reset_n = 1'b1;
    x = 8'd20; y = 7'd20; colour = 3'd2; plot = 1'b1;
    check("post_rst_ready", 32'(ready), 32'd1);
    tick();
    plot = 1'b0;
    check("post_rst_busy", 32'(idle), 32'd0);
    tick();
    read_px("post_rst_3220", 15'd3220, 3'd2);
    read_px("fifo_discard",  15'd4830, 3'd1);

`ifdef FB_CLEAR_EN
    begin
      int cyc;
      logic ready_seen;
      do_plot(8'd0, 7'd0, 3'd3);
      clear = 1'b1; clear_colour = 3'b111;
      tick();
      clear = 1'b0; clear_colour = 3'd0;
      check("clr_busy", 32'(clear_busy), 32'd1);
      cyc = 0; ready_seen = 1'b0;
      while (!idle && cyc < 25000) begin
        if (ready) ready_seen = 1'b1;
        tick();
        cyc++;
      end
      check("clr_ready_low", 32'(ready_seen), 32'd0);
      check("clr_cycles",    32'(cyc),        32'd19201);
      check("clr_done_busy", 32'(clear_busy), 32'd0);
      read_px("clr_0",     15'd0,     3'b111);
      read_px("clr_9600",  15'd9600,  3'b111);
      read_px("clr_19199", 15'd19199, 3'b111);

      // Reset midway through a clear
      clear = 1'b1; clear_colour = 3'd2;
      tick();
      clear = 1'b0;
      for (int i = 0; i < 5000; i++) tick();
      check("mid_clr_busy", 32'(clear_busy), 32'd1);
      #4 reset_n = 1'b0;
      #2;
      check("mid_rst_idle",  32'(idle),       32'd1);
      check("mid_rst_drop",  32'(drop_count), 32'd0);
      check("mid_rst_valid", 32'(rd_valid),   32'd0);
      tick();
      #3 reset_n = 1'b1;
      x = 8'd1; y = 7'd1; colour = 3'd5; plot = 1'b1;
      check("mid_rst_ready", 32'(ready), 32'd1);
      tick();
      plot = 1'b0;
      tick();
      read_px("mid_rst_161", 15'd161, 3'd5);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
